// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: default bus widths, arbiter states, byte-select width helper.
`ifndef WB_SEL_W
`define WB_SEL_W(dw) ((dw) / 8)
`endif

package wb_pkg;

    localparam int WB_AW = 32;
    localparam int WB_DW = 32;

    // Outstanding-request counter; the owner is stalled while it sits at its ceiling.
    localparam int               OUTST_W   = 4;
    localparam logic [OUTST_W-1:0] OUTST_MAX = '1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/wb_arb_rr2.sv
// Two-way round-robin pick: a sole requester wins; on a tie the master that did not own the bus last wins.
module wb_arb_rr2 (
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic       grant
);

    assign grant = (&req) ? ~rr_last : req[1];

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter: registered round-robin grant, held for the owner's whole CYC.
// Optional slave-timeout abort is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_arbiter2
    import wb_pkg::*;
#(
    parameter int AW      = WB_AW,
    parameter int DW      = WB_DW,
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_m0_cyc,
    input  logic                    i_m0_stb,
    input  logic                    i_m0_we,
    input  logic [AW-1:0]           i_m0_addr,
    input  logic [DW-1:0]           i_m0_data,
    input  logic [`WB_SEL_W(DW)-1:0] i_m0_sel,
    input  logic                    i_m1_cyc,
    input  logic                    i_m1_stb,
    input  logic                    i_m1_we,
    input  logic [AW-1:0]           i_m1_addr,
    input  logic [DW-1:0]           i_m1_data,
    input  logic [`WB_SEL_W(DW)-1:0] i_m1_sel,
    output logic                    o_m0_ack,
    output logic                    o_m0_err,
    output logic                    o_m0_stall,
    output logic [DW-1:0]           o_m0_data,
    output logic                    o_m1_ack,
    output logic                    o_m1_err,
    output logic                    o_m1_stall,
    output logic [DW-1:0]           o_m1_data,
    output logic                    o_wb_m2s_cyc,
    output logic                    o_wb_m2s_stb,
    output logic                    o_wb_m2s_we,
    output logic [AW-1:0]           o_wb_m2s_addr,
    output logic [DW-1:0]           o_wb_m2s_data,
    output logic [`WB_SEL_W(DW)-1:0] o_wb_m2s_sel,
    input  logic                    i_wb_s2m_ack,
    input  logic                    i_wb_s2m_err,
    input  logic                    i_wb_s2m_stall,
    input  logic [DW-1:0]           i_wb_s2m_data,
    output logic                    o_owner,
    output logic                    o_busy
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("wb_arbiter2: TIMEOUT must be in 1..255");
    end

    arb_state_t         state, state_nxt;
    logic               owner, owner_nxt;
    logic               rr_last, rr_last_nxt;
    logic [OUTST_W-1:0] outstanding, outstanding_nxt;
    logic               grant, busy, own_cyc, own_stb, own_stall;
    logic               accepted, resp, timeout_hit;

    wb_arb_rr2 u_rr (
        .req     ({i_m1_cyc, i_m0_cyc}),
        .rr_last (rr_last),
        .grant   (grant)
    );

    assign busy    = (state == ARB_BUSY);
    assign own_cyc = owner ? i_m1_cyc : i_m0_cyc;
    assign own_stb = owner ? i_m1_stb : i_m0_stb;

    // Slave side follows the owner combinationally, so a dropped CYC reaches the slave the same cycle.
    assign o_wb_m2s_cyc  = busy & own_cyc & ~timeout_hit;
    assign o_wb_m2s_stb  = busy & own_cyc & own_stb & ~timeout_hit;
    assign o_wb_m2s_we   = owner ? i_m1_we   : i_m0_we;
    assign o_wb_m2s_addr = owner ? i_m1_addr : i_m0_addr;
    assign o_wb_m2s_data = owner ? i_m1_data : i_m0_data;
    assign o_wb_m2s_sel  = owner ? i_m1_sel  : i_m0_sel;

    assign own_stall = i_wb_s2m_stall | (outstanding == OUTST_MAX);
    assign accepted  = o_wb_m2s_stb & ~own_stall;
    // Responses with nothing in flight, or after the owner let go, are dropped.
    assign resp      = o_wb_m2s_cyc & (i_wb_s2m_ack | i_wb_s2m_err) & (outstanding != '0);

    assign o_m0_stall = ~(busy & ~owner) | own_stall;
    assign o_m1_stall = ~(busy &  owner) | own_stall;
    assign o_m0_ack   = busy & ~owner & resp & i_wb_s2m_ack;
    assign o_m1_ack   = busy &  owner & resp & i_wb_s2m_ack;
    assign o_m0_err   = busy & ~owner & ((resp & i_wb_s2m_err) | timeout_hit);
    assign o_m1_err   = busy &  owner & ((resp & i_wb_s2m_err) | timeout_hit);
    assign o_m0_data  = i_wb_s2m_data;
    assign o_m1_data  = i_wb_s2m_data;

    assign o_owner = owner;
    assign o_busy  = busy;

`ifdef WB_ARB_TIMEOUT_EN
    logic [7:0] wd_cnt;
    logic       wd_run;

    assign wd_run      = busy & (outstanding != '0) & ~(i_wb_s2m_ack | i_wb_s2m_err);
    assign timeout_hit = wd_run & (wd_cnt == 8'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (i_reset || !wd_run || timeout_hit) wd_cnt <= '0;
        else                                   wd_cnt <= wd_cnt + 8'd1;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt       = state;
        owner_nxt       = owner;
        rr_last_nxt     = rr_last;
        outstanding_nxt = outstanding;
        case (state)
            ARB_IDLE: begin
                outstanding_nxt = '0;
                if (i_m0_cyc || i_m1_cyc) begin
                    state_nxt = ARB_BUSY;
                    owner_nxt = grant;
                end
            end
            ARB_BUSY: begin
                if (!own_cyc || timeout_hit) begin
                    state_nxt       = ARB_IDLE;
                    rr_last_nxt     = owner;
                    outstanding_nxt = '0;
                end else if (accepted && !resp) begin
                    outstanding_nxt = outstanding + OUTST_W'(1);
                end else if (resp && !accepted) begin
                    outstanding_nxt = outstanding - OUTST_W'(1);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state       <= ARB_IDLE;
            owner       <= 1'b0;
            rr_last     <= 1'b1;
            outstanding <= '0;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            rr_last     <= rr_last_nxt;
            outstanding <= outstanding_nxt;
        end
    end

endmodule
